// File: rtl/enigma_pkg.sv
// Shared alphabet constants, rotor position type and the inverse rotor wiring table.
package enigma_pkg;

  localparam int LETTERS = 26;

  typedef logic [4:0] pos_t;

  localparam pos_t A = 5'd0,  B = 5'd1,  C = 5'd2,  D = 5'd3,  E = 5'd4,  F = 5'd5;
  localparam pos_t G = 5'd6,  H = 5'd7,  I = 5'd8,  J = 5'd9,  K = 5'd10, L = 5'd11;
  localparam pos_t M = 5'd12, N = 5'd13, O = 5'd14, P = 5'd15, Q = 5'd16, R = 5'd17;
  localparam pos_t S = 5'd18, T = 5'd19, U = 5'd20, V = 5'd21, W = 5'd22, X = 5'd23;
  localparam pos_t Y = 5'd24, Z = 5'd25;

  // Default wiring is an involution (pairs AR BD CF EH GJ IZ KM LO NQ PS TV UX WY),
  // so the inverse table is identical to the forward one.
  localparam pos_t INV_WIRING [LETTERS] = '{
    R, D, F, B, H, C, J, E, Z, G, M, O, K,
    Q, L, S, N, A, P, V, X, T, Y, U, W, I
  };

endpackage

// File: rtl/onehot_rotate.sv
// Combinational cyclic rotate of a 26-bit word by 0..25 places, left (+) or right (-).
module onehot_rotate
  import enigma_pkg::*;
(
  input  logic [LETTERS-1:0] data_in,
  input  pos_t               amount,
  input  logic               dir_left,
  output logic [LETTERS-1:0] data_out
);

  // A zero amount shifts the wrap-around term by the full width, which yields zero.
  always_comb begin
    if (dir_left) begin
      data_out = (data_in << amount) | (data_in >> (LETTERS - int'(amount)));
    end else begin
      data_out = (data_in >> amount) | (data_in << (LETTERS - int'(amount)));
    end
  end

endmodule

// File: rtl/rotor_inverse.sv
// Inverse-path Enigma rotor: one-cycle one-hot letter translation plus rotor position/notch logic.
module rotor_inverse
  import enigma_pkg::*;
#(
  parameter int NOTCH   = 16,
  parameter int LETTERS = 26
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [LETTERS-1:0] in_data,
  input  logic               step,
  input  logic               load,
  input  logic [4:0]         load_pos,
  output logic               out_valid,
  output logic [LETTERS-1:0] out_data,
  output logic               err,
  output logic [4:0]         pos,
  output logic               carry_out
);

  pos_t               pos_q, pos_d;
  logic               carry_q, carry_d;
  logic               out_valid_q, out_valid_d;
  logic [LETTERS-1:0] out_data_q, out_data_d;
  logic               err_q, err_d;

  logic [LETTERS-1:0] rot_in, mapped, rot_out;
  logic               is_onehot;

  onehot_rotate u_rot_in (
    .data_in  (in_data),
    .amount   (pos_q),
    .dir_left (1'b0),
    .data_out (rot_in)
  );

  onehot_rotate u_rot_out (
    .data_in  (mapped),
    .amount   (pos_q),
    .dir_left (1'b1),
    .data_out (rot_out)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mapped = '0;
    for (int i = 0; i < LETTERS; i++) begin
      mapped[INV_WIRING[i]] = rot_in[i];
    end
  end

  assign is_onehot = (in_data != '0) && ((in_data & (in_data - 1'b1)) == '0);

  always_comb begin
    out_valid_d = in_valid;
    err_d       = in_valid && !is_onehot;
    out_data_d  = (in_valid && is_onehot) ? rot_out : '0;
  end

  // Load beats step; the notch carry belongs only to a step that actually happened.
  always_comb begin
    pos_d   = pos_q;
    carry_d = 1'b0;
    if (load) begin
      pos_d = (load_pos >= pos_t'(LETTERS)) ? '0 : load_pos;
    end else if (step) begin
      pos_d   = (pos_q == pos_t'(LETTERS - 1)) ? '0 : pos_q + 5'd1;
      carry_d = (pos_q == pos_t'(NOTCH));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign pos       = pos_q;
  assign carry_out = carry_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rotor_inverse.sv
// Self-checking bench for rotor_inverse: directed vector table, multi-cycle sequences, random run vs model.
module tb_rotor_inverse;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [25:0] in_data = '0;
  logic        step = 1'b0;
  logic        load = 1'b0;
  logic [4:0]  load_pos = '0;
  logic        out_valid;
  logic [25:0] out_data;
  logic        err;
  logic [4:0]  pos;
  logic        carry_out;

  int total = 0;
  int bad   = 0;

  int model_inv [26];
  int pairs [13][2] = '{'{0,17}, '{1,3}, '{2,5}, '{4,7}, '{6,9}, '{8,25}, '{10,12},
                        '{11,14}, '{13,16}, '{15,18}, '{19,21}, '{20,23}, '{22,24}};

  rotor_inverse #(.NOTCH(16), .LETTERS(26)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .step      (step),
    .load      (load),
    .load_pos  (load_pos),
    .out_valid (out_valid),
    .out_data  (out_data),
    .err       (err),
    .pos       (pos),
    .carry_out (carry_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld;
    logic [4:0]  lp;
    logic        st;
    logic        iv;
    logic [25:0] din;
    logic        e_ov;
    logic [25:0] e_od;
    logic        e_err;
    logic [4:0]  e_pos;
    logic        e_car;
    string       name;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [4:0] lp, input logic st,
                       input logic iv, input logic [25:0] din);
    load = ld; load_pos = lp; step = st; in_valid = iv; in_data = din;
  endtask

  function automatic int expected_index(input int a, input int p);
    return (model_inv[(a - p + 26) % 26] + p) % 26;
  endfunction

  function automatic int bit_count(input logic [25:0] w);
    int c = 0;
    for (int i = 0; i < 26; i++) if (w[i]) c++;
    return c;
  endfunction

  function automatic int low_index(input logic [25:0] w);
    for (int i = 0; i < 26; i++) if (w[i]) return i;
    return 0;
  endfunction

  initial begin
    int mpos;
    int carries;
    int a;
    logic [25:0] din;
    logic [25:0] e_od;
    logic        e_err, e_car;
    logic        ld, st, iv;
    logic [4:0]  lp;
    int          npos;

    foreach (pairs[k]) begin
      model_inv[pairs[k][0]] = pairs[k][1];
      model_inv[pairs[k][1]] = pairs[k][0];
    end

    // Directed table, starting from pos 0 after reset.
    vecs.push_back('{0, 0,  0, 1, 26'(1) << 17, 1, 26'(1) << 0, 0, 0,  0, "R_at_0"});
    vecs.push_back('{1, 1,  0, 0, 26'(0),       0, 26'(0),      0, 1,  0, "load_1"});
    vecs.push_back('{0, 0,  0, 1, 26'(1) << 9,  1, 26'(1) << 0, 0, 1,  0, "J_at_1"});
    vecs.push_back('{0, 0,  0, 1, 26'(1) << 0,  1, 26'(1) << 9, 0, 1,  0, "A_at_1"});
    vecs.push_back('{1, 16, 0, 0, 26'(0),       0, 26'(0),      0, 16, 0, "load_16"});
    vecs.push_back('{0, 0,  1, 0, 26'(0),       0, 26'(0),      0, 17, 1, "step_notch"});
    vecs.push_back('{0, 0,  0, 0, 26'(0),       0, 26'(0),      0, 17, 0, "carry_one_cycle"});
    vecs.push_back('{1, 25, 0, 0, 26'(0),       0, 26'(0),      0, 25, 0, "load_25"});
    vecs.push_back('{0, 0,  1, 0, 26'(0),       0, 26'(0),      0, 0,  0, "wrap_25"});
    vecs.push_back('{1, 16, 0, 0, 26'(0),       0, 26'(0),      0, 16, 0, "reload_16"});
    vecs.push_back('{0, 0,  1, 1, 26'(1) << 16, 1, 26'(1) << 7, 0, 17, 1, "data_pre_step"});
    vecs.push_back('{1, 16, 0, 0, 26'(0),       0, 26'(0),      0, 16, 0, "reload_16b"});
    vecs.push_back('{1, 30, 1, 0, 26'(0),       0, 26'(0),      0, 0,  0, "load30_over_step"});
    vecs.push_back('{0, 0,  0, 1, 26'(0),       1, 26'(0),      1, 0,  0, "zero_word"});
    vecs.push_back('{0, 0,  0, 1, 26'h28,       1, 26'(0),      1, 0,  0, "two_bits"});
    vecs.push_back('{0, 0,  0, 0, 26'h28,       0, 26'(0),      0, 0,  0, "idle"});

    // Reset state, asynchronous and before any clock edge matters.
    #2;
    check("rst_pos", 32'(pos), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_err", 32'(err), 0);
    check("rst_carry", 32'(carry_out), 0);
    tick();
    reset = 1'b1;
    tick();

    foreach (vecs[k]) begin
      drive(vecs[k].ld, vecs[k].lp, vecs[k].st, vecs[k].iv, vecs[k].din);
      tick();
      check({vecs[k].name, "_ov"},  32'(out_valid), 32'(vecs[k].e_ov));
      check({vecs[k].name, "_od"},  32'(out_data),  32'(vecs[k].e_od));
      check({vecs[k].name, "_err"}, 32'(err),       32'(vecs[k].e_err));
      check({vecs[k].name, "_pos"}, 32'(pos),       32'(vecs[k].e_pos));
      check({vecs[k].name, "_car"}, 32'(carry_out), 32'(vecs[k].e_car));
    end

    // Step held for 30 cycles from pos 3: ends at 7 and passes the notch exactly once.
    drive(1, 3, 0, 0, '0);
    tick();
    drive(0, 0, 1, 0, '0);
    carries = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (carry_out) carries++;
    end
    drive(0, 0, 0, 0, '0);
    tick();
    if (carry_out) carries++;
    check("held_step_pos", 32'(pos), 7);
    check("held_step_carries", 32'(carries), 1);

    // Every letter at every position.
    for (int p = 0; p < 26; p++) begin
      drive(1, 5'(p), 0, 0, '0);
      tick();
      for (int l = 0; l < 26; l++) begin
        drive(0, 0, 0, 1, 26'(1) << l);
        tick();
        check($sformatf("sweep_p%0d_l%0d", p, l), 32'(out_data),
              32'(26'(1) << expected_index(l, p)));
      end
    end
    drive(0, 0, 0, 0, '0);

    // Random traffic against the model.
    drive(1, 0, 0, 0, '0);
    tick();
    mpos = 0;
    for (int n = 0; n < 400; n++) begin
      ld = ($urandom_range(0, 9) == 0);
      lp = 5'($urandom_range(0, 31));
      st = ($urandom_range(0, 9) < 4);
      iv = ($urandom_range(0, 9) < 7);
      a  = $urandom_range(0, 25);
      din = ($urandom_range(0, 7) == 0) ? 26'($urandom) : (26'(1) << a);
      e_err = iv && (bit_count(din) != 1);
      e_od  = (iv && !e_err) ? 26'(1) << expected_index(low_index(din), mpos) : '0;
      e_car = !ld && st && (mpos == 16);
      if (ld) npos = (int'(lp) > 25) ? 0 : int'(lp);
      else if (st) npos = (mpos + 1) % 26;
      else npos = mpos;
      drive(ld, lp, st, iv, din);
      tick();
      check("rnd_ov",  32'(out_valid), 32'(iv));
      check("rnd_od",  32'(out_data),  32'(e_od));
      check("rnd_err", 32'(err),       32'(e_err));
      check("rnd_pos", 32'(pos),       32'(npos));
      check("rnd_car", 32'(carry_out), 32'(e_car));
      mpos = npos;
    end

    // Asynchronous reset in mid-stream with pos 12 and a valid output pending.
    drive(1, 12, 0, 0, '0);
    tick();
    drive(0, 0, 0, 1, 26'(1) << 4);
    tick();
    check("pre_rst_ov", 32'(out_valid), 1);
    check("pre_rst_pos", 32'(pos), 12);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_pos", 32'(pos), 0);
    check("async_rst_ov", 32'(out_valid), 0);
    check("async_rst_od", 32'(out_data), 0);
    check("async_rst_err", 32'(err), 0);
    check("async_rst_car", 32'(carry_out), 0);
    drive(0, 0, 1, 1, 26'(1) << 4);
    tick();
    check("in_rst_ov", 32'(out_valid), 0);
    check("in_rst_pos", 32'(pos), 0);
    reset = 1'b1;
    drive(0, 0, 0, 1, 26'(1) << 17);
    tick();
    check("first_edge_ov", 32'(out_valid), 1);
    check("first_edge_od", 32'(out_data), 32'(26'(1)));
    drive(0, 0, 0, 0, '0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotor_inverse.md
ROTOR_INVERSE -- requirements
Module: rotor_inverse

Interface
REQ-001 The parameter NOTCH SHALL default to 16 (letter Q) and SHALL set the position at which stepping produces carry_out.
REQ-002 The parameter LETTERS SHALL default to 26 and SHALL set the alphabet size, fixed at 26 for this release.
REQ-003 Port clock SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-low reset.
REQ-005 Port in_valid SHALL be an input, 1 bit wide, and SHALL qualify in_data for one cycle.
REQ-006 Port in_data SHALL be an input, 26 bits wide, carrying a one-hot letter arriving from the reflector side (bit 0 = A).
REQ-007 Port step SHALL be an input, 1 bit wide, and SHALL request a single-cycle advance of the rotor position.
REQ-008 Port load SHALL be an input, 1 bit wide, and SHALL request a synchronous position load.
REQ-009 Port load_pos SHALL be an input, 5 bits wide, and SHALL carry the position value for a load.
REQ-010 Port out_valid SHALL be an output, 1 bit wide, and SHALL qualify out_data and err.
REQ-011 Port out_data SHALL be an output, 26 bits wide, carrying the one-hot letter toward the keyboard side.
REQ-012 Port err SHALL be an output, 1 bit wide, and SHALL flag a malformed in_data word.
REQ-013 Port pos SHALL be an output, 5 bits wide, giving the current rotor position 0..25.
REQ-014 Port carry_out SHALL be an output, 1 bit wide, carrying a one-cycle step pulse for the next rotor.

Function
REQ-015 The data path SHALL apply the inverse of the team default rotor wiring, using the INV_WIRING table (the default wiring is an involution, so INV_WIRING equals the forward table entry-for-entry).
REQ-016 For in_data with a single bit set at index a, out_data SHALL have exactly one bit set at index (INV_WIRING[(a - pos) mod 26] + pos) mod 26.
REQ-017 Latency SHALL be one cycle: out_valid, out_data and err SHALL be registered from the in_valid cycle and SHALL be held for exactly one cycle.
REQ-018 When in_valid=0, out_valid SHALL be 0 on the next cycle, and out_data and err SHALL both be 0.
REQ-019 When in_valid=1 and in_data is not one-hot (zero bits set, or two or more bits set), the block SHALL produce out_valid=1, err=1 and out_data=0.
REQ-020 Position update priority SHALL be: load first, then step, otherwise hold.
REQ-021 On a load, pos SHALL take the value of load_pos; a load_pos value of 26..31 SHALL load 0 instead.
REQ-022 On a step, pos SHALL become (pos+1) mod 26, so that a step at 25 wraps to 0.
REQ-023 carry_out SHALL be registered and SHALL pulse for one cycle on the cycle after a step taken while pos==NOTCH.
REQ-024 carry_out SHALL NOT assert when the step was overridden by a load.
REQ-025 When in_valid and step (or load) occur in the same cycle, the data SHALL be translated using the pre-update pos.
REQ-026 A step held high for N cycles SHALL advance pos by N.

Reset
REQ-027 While reset=0, pos, out_valid, out_data, err and carry_out SHALL all be 0, asynchronously.
REQ-028 An in_valid asserted during reset or in the same edge as reset release SHALL be discarded.
REQ-029 After reset release, the first rising clock edge SHALL be a normal operating edge.

Structure
REQ-030 Package enigma_pkg SHALL hold LETTERS, the letter index constants A..Z (0..25), the 26-entry INV_WIRING table, and the 5-bit position type.
REQ-031 A combinational sub-module, onehot_rotate, SHALL perform a cyclic rotate of a 26-bit word by 0..25 in either direction.
REQ-032 onehot_rotate SHALL be instantiated twice: once to rotate in by -pos and once to rotate out by +pos.
REQ-033 The inverse table lookup and the one-hot check SHALL be local to rotor_inverse.

Verification
REQ-034 Reset, pos=0, in_data one-hot index 17 (R) with in_valid=1 -> next cycle out_valid=1, out_data one-hot index 0 (A), err=0.
REQ-035 Load load_pos=1, then in_data index 9 (J) -> out_data index 0 (A); then in_data index 0 at pos=1 -> out_data index 9.
REQ-036 Load 16, assert step for one cycle -> pos=17 and carry_out=1 for exactly one cycle; step at pos=25 -> pos=0 with no carry_out.
REQ-037 load=1 with load_pos=30 and step=1 in the same cycle -> pos=0 and carry_out=0.
REQ-038 in_data=0 and, separately, in_data with bits 3 and 5 set, with in_valid=1 -> out_valid=1, err=1, out_data=0.
REQ-039 Drive reset low mid-stream with pos=12 and out_valid=1 -> all outputs 0 immediately, before the next clock edge; sweep all 26 letters at all 26 positions and check the result against the REQ-016 formula.
